// File: rtl/pipereg_skid_pkg.sv
// Shared defines for the two-entry skid pipeline register: state encodings and
// per-stage payload widths so each instantiation picks DATA_WIDTH by name.
package pipereg_skid_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  localparam int RENAME_DISPATCH_DATA_W = 64;
  localparam int ISSUE_EXU_DATA_W       = 96;
  localparam int SKID_DEFAULT_DATA_W    = RENAME_DISPATCH_DATA_W;

endpackage

// File: rtl/pipereg_skid.sv
// Two-entry skid register: 1-cycle latency, 1 transfer/cycle when downstream is ready.
// instr_ready is decoded from the state register only; the skid entry absorbs its one-cycle lag.
module pipereg_skid
  import pipereg_skid_pkg::*;
#(
  parameter int DATA_WIDTH = SKID_DEFAULT_DATA_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  redirect_flush,
  output logic                  lower_instr_valid,
  input  logic                  lower_instr_ready,
  output logic [DATA_WIDTH-1:0] lower_data
);

  skid_state_e           state_q, state_nxt;
  logic [DATA_WIDTH-1:0] main_q, skid_q;
  logic                  in_fire, lower_fire;
  logic                  main_ld, main_from_skid, skid_ld, clr;

  assign lower_instr_valid = (state_q != SKID_EMPTY);
  assign instr_ready       = (state_q != SKID_FULL);
  assign lower_data        = main_q;

  assign in_fire    = instr_valid & instr_ready;
  assign lower_fire = lower_instr_valid & lower_instr_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SKID_EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    clr            = 1'b0;
    if (redirect_flush) begin
      // Flush discards any same-cycle transfer on either side.
      state_nxt = SKID_EMPTY;
      clr       = 1'b1;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (in_fire) begin
            main_ld   = 1'b1;
            state_nxt = SKID_BUSY;
          end
        end
        SKID_BUSY: begin
          if (in_fire && lower_fire) begin
            main_ld = 1'b1;
          end else if (in_fire) begin
            skid_ld   = 1'b1;
            state_nxt = SKID_FULL;
          end else if (lower_fire) begin
            state_nxt = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (lower_fire) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            state_nxt      = SKID_BUSY;
          end
        end
        default: begin
          state_nxt = SKID_EMPTY;
        end
      endcase
    end
  end

  // Payload is left stale when an entry leaves; only state qualifies it downstream.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (clr) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_ld) begin
        main_q <= main_from_skid ? skid_q : data;
      end
      if (skid_ld) begin
        skid_q <= data;
      end
    end
  end

endmodule

// File: tb/tb_pipereg_skid.sv
// Randomized and directed check of pipereg_skid against a queue-based reference model.
module tb_pipereg_skid;
  localparam int W = 64;

  logic         clock;
  logic         reset_n;
  logic         instr_valid;
  logic         instr_ready;
  logic [W-1:0] data;
  logic         redirect_flush;
  logic         lower_instr_valid;
  logic         lower_instr_ready;
  logic [W-1:0] lower_data;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] exp_main;

  pipereg_skid #(.DATA_WIDTH(W)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .data              (data),
    .redirect_flush    (redirect_flush),
    .lower_instr_valid (lower_instr_valid),
    .lower_instr_ready (lower_instr_ready),
    .lower_data        (lower_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic lr, input logic fl);
    instr_valid       = v;
    data              = d;
    lower_instr_ready = lr;
    redirect_flush    = fl;
  endtask

  // One clock: model decides transfers from the queue occupancy, then checks outputs after the edge.
  task automatic tick();
    bit           in_f, lo_f, fl;
    logic [W-1:0] din;
    in_f = instr_valid && (mq.size() < 2);
    lo_f = lower_instr_ready && (mq.size() > 0);
    fl   = redirect_flush;
    din  = data;
    if (lo_f) check_eq("deliver", lower_data, mq[0]);
    @(posedge clock);
    if (fl) begin
      mq.delete();
      exp_main = '0;
    end else begin
      if (lo_f) void'(mq.pop_front());
      if (in_f) mq.push_back(din);
    end
    if (mq.size() > 0) exp_main = mq[0];
    #1;
    check_eq("valid", {63'd0, lower_instr_valid}, {63'd0, mq.size() > 0});
    check_eq("ready", {63'd0, instr_ready}, {63'd0, mq.size() < 2});
    check_eq("data", lower_data, exp_main);
  endtask

  initial begin
    logic r0;
    reset_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    exp_main = '0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_valid", {63'd0, lower_instr_valid}, 64'd0);
    check_eq("rst_data", lower_data, 64'd0);
    check_eq("rst_ready", {63'd0, instr_ready}, 64'd1);
    @(negedge clock);
    reset_n = 1'b1;

    // Streaming
    drive(1'b1, 64'h1, 1'b1, 1'b0); tick();
    check_eq("stream1", lower_data, 64'h1);
    drive(1'b1, 64'h2, 1'b1, 1'b0); tick();
    check_eq("stream2", lower_data, 64'h2);
    check_eq("stream_rdy", {63'd0, instr_ready}, 64'd1);
    drive(1'b1, 64'h3, 1'b1, 1'b0); tick();
    check_eq("stream3", lower_data, 64'h3);
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    check_eq("stream_empty", {63'd0, lower_instr_valid}, 64'd0);

    // Skid fill then release
    drive(1'b1, 64'hA, 1'b0, 1'b0); tick();
    drive(1'b1, 64'hB, 1'b0, 1'b0); tick();
    check_eq("fill_rdy", {63'd0, instr_ready}, 64'd0);
    check_eq("fill_data", lower_data, 64'hA);
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    check_eq("release_data", lower_data, 64'hB);
    check_eq("release_rdy", {63'd0, instr_ready}, 64'd1);
    tick();
    check_eq("release_empty", {63'd0, lower_instr_valid}, 64'd0);

    // Drain from FULL with no input
    drive(1'b1, 64'hA, 1'b0, 1'b0); tick();
    drive(1'b1, 64'hB, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    check_eq("drain_b", lower_data, 64'hB);
    tick();
    check_eq("drain_done", {63'd0, lower_instr_valid}, 64'd0);
    check_eq("drain_stale", lower_data, 64'hB);

    // Flush from FULL with downstream ready
    drive(1'b1, 64'hC, 1'b0, 1'b0); tick();
    drive(1'b1, 64'hD, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b1, 1'b1); tick();
    check_eq("flush_valid", {63'd0, lower_instr_valid}, 64'd0);
    check_eq("flush_data", lower_data, 64'd0);
    check_eq("flush_ready", {63'd0, instr_ready}, 64'd1);
    drive(1'b0, '0, 1'b1, 1'b0); tick();

    // Async reset between edges while BUSY
    drive(1'b1, 64'h55, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_valid", {63'd0, lower_instr_valid}, 64'd0);
    check_eq("arst_data", lower_data, 64'd0);
    check_eq("arst_ready", {63'd0, instr_ready}, 64'd1);
    mq.delete();
    exp_main = '0;
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Random traffic with occasional flush
    for (int i = 0; i < 1000; i++) begin
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 2) != 0,
            $urandom_range(0, 63) == 0);
      r0 = instr_ready;
      lower_instr_ready = ~lower_instr_ready;
      #1;
      check_eq("rdy_indep", {63'd0, instr_ready}, {63'd0, r0});
      lower_instr_ready = ~lower_instr_ready;
      #1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
